// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - LEGv8 instruction fetch stage with PC, fetch FSM and instruction buffer
//
// Holds the PC and issues one word fetch at a time over a request/grant/response
// handshake. Returned words go into a small circular buffer for decode. A taken
// branch redirects fetch to BranchPC + SEUOut, flushes the buffer and drops any
// response still in flight.
//
// Optional feature macro: IFU_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target sets MisalignFault and halts fetch
//               until reset.
//   undefined : target bits [1:0] are cleared and fetch continues; MisalignFault = 0.
//
// Parameters:
//   PC_RESET    - PC value loaded on reset
//   IBUF_DEPTH  - instruction buffer entries (power of two, >= 2)
//
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   IMemReq/IMemAddr/IMemGnt     - fetch request, byte address, grant
//   IMemRValid/IMemRData         - fetch response
//   BranchTaken/BranchPC/SEUOut  - redirect request, branch PC, byte offset
//   InstValid/InstReady          - buffer head valid / decode consumes head
//   Inst/InstPC/Inst25           - head instruction, its PC, Inst[25:0]
//   MisalignFault                - sticky misaligned-target flag

module instruction_fetch_unit #(
    parameter logic [63:0] PC_RESET   = 64'h0,
    parameter int          IBUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               IMemReq,
    output logic [63:0]        IMemAddr,
    input  logic               IMemGnt,
    input  logic               IMemRValid,
    input  logic [31:0]        IMemRData,
    input  logic               BranchTaken,
    input  logic [63:0]        BranchPC,
    input  logic signed [63:0] SEUOut,
    output logic               InstValid,
    input  logic               InstReady,
    output logic [31:0]        Inst,
    output logic [63:0]        InstPC,
    output logic [25:0]        Inst25,
    output logic               MisalignFault
);

    localparam int PW = $clog2(IBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
`ifdef IFU_MISALIGN_TRAP_EN
        , S_HALT  = 2'd3
`endif
    } state_t;

    state_t        r_state;
    logic [63:0]   r_pc;
    logic [63:0]   r_req_pc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic          r_misalign;
    logic [31:0]   r_buf_inst [IBUF_DEPTH];
    logic [63:0]   r_buf_pc   [IBUF_DEPTH];

    logic [63:0]   w_target;
    logic          w_pending;
    logic [CW-1:0] w_occupancy;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic          w_redirect;

    // Two's complement add; the unsigned view gives the same mod 2^64 result.
    assign w_target    = BranchPC + SEUOut;
    assign w_pending   = (r_state == S_WAIT);
    // Counting the in-flight request keeps a full buffer from ever being overrun.
    assign w_occupancy = r_count + CW'(w_pending);

    assign IMemReq  = reset_n && (r_state == S_FETCH) && (w_occupancy < DEPTH_C) && !BranchTaken;
    assign IMemAddr = r_pc;
    assign w_grant  = IMemReq && IMemGnt;

    // Once halted, further branches have nothing left to redirect.
`ifdef IFU_MISALIGN_TRAP_EN
    assign w_redirect = BranchTaken && (r_state != S_HALT);
`else
    assign w_redirect = BranchTaken;
`endif

    assign w_push = (r_state == S_WAIT) && IMemRValid && !BranchTaken;
    assign w_pop  = InstValid && InstReady && !BranchTaken;

    assign InstValid     = (r_count != '0);
    assign Inst          = InstValid ? r_buf_inst[r_rd_ptr] : 32'h0;
    assign InstPC        = InstValid ? r_buf_pc[r_rd_ptr]   : 64'h0;
    assign Inst25        = Inst[25:0];
    assign MisalignFault = r_misalign;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_FETCH;
            r_pc       <= PC_RESET;
            r_req_pc   <= PC_RESET;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_misalign <= 1'b0;
        end else if (w_redirect) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
            if (w_target[1:0] != 2'b00) begin
                r_misalign <= 1'b1;
                r_state    <= S_HALT;
            end else begin
                r_pc <= w_target;
                // A response still owed by memory must be swallowed before refetching.
                if ((r_state == S_WAIT || r_state == S_DISCARD) && !IMemRValid)
                    r_state <= S_DISCARD;
                else
                    r_state <= S_FETCH;
            end
`else
            r_pc <= {w_target[63:2], 2'b00};
            if ((r_state == S_WAIT || r_state == S_DISCARD) && !IMemRValid)
                r_state <= S_DISCARD;
            else
                r_state <= S_FETCH;
`endif
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_grant) begin
                        r_state  <= S_WAIT;
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + 64'd4;
                    end
                end
                S_WAIT: begin
                    if (IMemRValid)
                        r_state <= S_FETCH;
                end
                S_DISCARD: begin
                    if (IMemRValid)
                        r_state <= S_FETCH;
                end
`ifdef IFU_MISALIGN_TRAP_EN
                S_HALT: r_state <= S_HALT;
`endif
                default: r_state <= S_FETCH;
            endcase

            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_inst[r_wr_ptr] <= IMemRData;
            r_buf_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit

module tb_instruction_fetch_unit;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               IMemReq;
    logic [63:0]        IMemAddr;
    logic               IMemGnt;
    logic               IMemRValid;
    logic [31:0]        IMemRData;
    logic               BranchTaken;
    logic [63:0]        BranchPC;
    logic signed [63:0] SEUOut;
    logic               InstValid;
    logic               InstReady;
    logic [31:0]        Inst;
    logic [63:0]        InstPC;
    logic [25:0]        Inst25;
    logic               MisalignFault;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.PC_RESET(64'h0), .IBUF_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
        .IMemRValid(IMemRValid), .IMemRData(IMemRData),
        .BranchTaken(BranchTaken), .BranchPC(BranchPC), .SEUOut(SEUOut),
        .InstValid(InstValid), .InstReady(InstReady), .Inst(Inst),
        .InstPC(InstPC), .Inst25(Inst25), .MisalignFault(MisalignFault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        IMemGnt = 1'b0; IMemRValid = 1'b0; IMemRData = 32'h0;
        BranchTaken = 1'b0; BranchPC = 64'h0; SEUOut = 64'sd0; InstReady = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        #1;
        n_cmp++; if (IMemReq !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", IMemReq); end
        n_cmp++; if (IMemAddr !== 64'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", IMemAddr); end
        n_cmp++; if (InstValid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", InstValid); end
        n_cmp++; if (Inst !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h want 0", Inst); end
        n_cmp++; if (InstPC !== 64'h0) begin n_err++; $display("FAIL rst_instpc: got %h want 0", InstPC); end
        n_cmp++; if (Inst25 !== 26'h0) begin n_err++; $display("FAIL rst_inst25: got %h want 0", Inst25); end
        n_cmp++; if (MisalignFault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b want 0", MisalignFault); end
    endtask

    task automatic test_sequential();
        logic [31:0] d [4];
        for (int k = 0; k < 4; k++) d[k] = 32'h1234_5670 + 32'h0101_0101 * k;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            IMemGnt = 1'b1; IMemRValid = 1'b0; InstReady = 1'b1;
            #1;
            n_cmp++; if (IMemReq !== 1'b1) begin n_err++; $display("FAIL seq_req k=%0d: got %b want 1", k, IMemReq); end
            n_cmp++; if (IMemAddr !== 64'(4 * k)) begin n_err++; $display("FAIL seq_addr k=%0d: got %h want %h", k, IMemAddr, 4 * k); end
            if (k == 0) begin
                n_cmp++; if (InstValid !== 1'b0) begin n_err++; $display("FAIL seq_valid0: got %b want 0", InstValid); end
            end else begin
                n_cmp++; if (InstValid !== 1'b1) begin n_err++; $display("FAIL seq_valid k=%0d: got %b want 1", k, InstValid); end
                n_cmp++; if (Inst !== d[k-1]) begin n_err++; $display("FAIL seq_inst k=%0d: got %h want %h", k, Inst, d[k-1]); end
                n_cmp++; if (InstPC !== 64'(4 * (k - 1))) begin n_err++; $display("FAIL seq_pc k=%0d: got %h want %h", k, InstPC, 4 * (k - 1)); end
                n_cmp++; if (Inst25 !== d[k-1][25:0]) begin n_err++; $display("FAIL seq_inst25 k=%0d: got %h want %h", k, Inst25, d[k-1][25:0]); end
            end
            tick();
            IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = d[k];
            #1;
            n_cmp++; if (IMemReq !== 1'b0) begin n_err++; $display("FAIL seq_wait_req k=%0d: got %b want 0", k, IMemReq); end
            if (k == 0) begin
                n_cmp++; if (InstValid !== 1'b0) begin n_err++; $display("FAIL seq_valid_c1: got %b want 0", InstValid); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int n_req = 0;
        int n_resp = 0;
        logic outstanding = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            IMemGnt = 1'b1; InstReady = 1'b0;
            IMemRValid = outstanding;
            IMemRData = 32'hE000_0000 + n_resp;
            if (outstanding) n_resp++;
            #1;
            if (IMemReq) n_req++;
            outstanding = IMemReq;
            tick();
        end
        IMemGnt = 1'b0; IMemRValid = 1'b0; InstReady = 1'b1;
        #1;
        n_cmp++; if (n_req !== 2) begin n_err++; $display("FAIL bp_nreq: got %0d want 2", n_req); end
        n_cmp++; if (IMemReq !== 1'b0) begin n_err++; $display("FAIL bp_full_req: got %b want 0", IMemReq); end
        n_cmp++; if (Inst !== 32'hE000_0000) begin n_err++; $display("FAIL bp_head0: got %h want e0000000", Inst); end
        tick();
        InstReady = 1'b0; IMemGnt = 1'b1;
        #1;
        n_cmp++; if (IMemReq !== 1'b1) begin n_err++; $display("FAIL bp_resume_req: got %b want 1", IMemReq); end
        n_cmp++; if (IMemAddr !== 64'h8) begin n_err++; $display("FAIL bp_resume_addr: got %h want 8", IMemAddr); end
        n_cmp++; if (InstPC !== 64'h4) begin n_err++; $display("FAIL bp_head1_pc: got %h want 4", InstPC); end
        tick();
        IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'hE000_0002; InstReady = 1'b1;
        tick();
        IMemRValid = 1'b0; InstReady = 1'b0;
        #1;
        n_cmp++; if (Inst !== 32'hE000_0002) begin n_err++; $display("FAIL bp_pushpop_inst: got %h want e0000002", Inst); end
        n_cmp++; if (InstPC !== 64'h8) begin n_err++; $display("FAIL bp_pushpop_pc: got %h want 8", InstPC); end
        n_cmp++; if (IMemAddr !== 64'hC) begin n_err++; $display("FAIL bp_pushpop_addr: got %h want c", IMemAddr); end
        idle_inputs();
    endtask

    task automatic test_branch_wait();
        do_reset();
        IMemGnt = 1'b1;
        tick();
        IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'hB000_0000;
        tick();
        IMemRValid = 1'b0; IMemGnt = 1'b1;
        #1;
        n_cmp++; if (InstValid !== 1'b1) begin n_err++; $display("FAIL br_prefill: got %b want 1", InstValid); end
        tick();
        IMemGnt = 1'b1; BranchTaken = 1'b1; BranchPC = 64'h100; SEUOut = -64'sd8;
        #1;
        n_cmp++; if (IMemReq !== 1'b0) begin n_err++; $display("FAIL br_req_forced: got %b want 0", IMemReq); end
        tick();
        BranchTaken = 1'b0; IMemGnt = 1'b1;
        #1;
        n_cmp++; if (InstValid !== 1'b0) begin n_err++; $display("FAIL br_flush: got %b want 0", InstValid); end
        n_cmp++; if (IMemReq !== 1'b0) begin n_err++; $display("FAIL br_discard_req: got %b want 0", IMemReq); end
        n_cmp++; if (IMemAddr !== 64'hF8) begin n_err++; $display("FAIL br_target: got %h want f8", IMemAddr); end
        IMemRValid = 1'b1; IMemRData = 32'hBAD0_0BAD; IMemGnt = 1'b0;
        tick();
        IMemRValid = 1'b0;
        #1;
        n_cmp++; if (InstValid !== 1'b0) begin n_err++; $display("FAIL br_dropped: got %b want 0", InstValid); end
        n_cmp++; if (IMemReq !== 1'b1) begin n_err++; $display("FAIL br_refetch_req: got %b want 1", IMemReq); end
        n_cmp++; if (IMemAddr !== 64'hF8) begin n_err++; $display("FAIL br_refetch_addr: got %h want f8", IMemAddr); end
        idle_inputs();
    endtask

    task automatic test_branch_wrap();
        do_reset();
        IMemGnt = 1'b1; BranchTaken = 1'b1; BranchPC = 64'hFFFF_FFFF_FFFF_FFFC; SEUOut = 64'sd8;
        #1;
        n_cmp++; if (IMemReq !== 1'b0) begin n_err++; $display("FAIL wrap_req_forced: got %b want 0", IMemReq); end
        tick();
        BranchTaken = 1'b0; IMemGnt = 1'b0;
        #1;
        n_cmp++; if (IMemAddr !== 64'h4) begin n_err++; $display("FAIL wrap_target: got %h want 4", IMemAddr); end
        n_cmp++; if (IMemReq !== 1'b1) begin n_err++; $display("FAIL wrap_gnt_cancel: got %b want 1", IMemReq); end
        idle_inputs();
    endtask

    task automatic test_misalign();
        do_reset();
        BranchTaken = 1'b1; BranchPC = 64'h200; SEUOut = 64'sd2;
        tick();
        BranchTaken = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        #1;
        n_cmp++; if (MisalignFault !== 1'b1) begin n_err++; $display("FAIL mis_fault: got %b want 1", MisalignFault); end
        for (int c = 0; c < 3; c++) begin
            IMemGnt = 1'b1;
            #1;
            n_cmp++; if (IMemReq !== 1'b0) begin n_err++; $display("FAIL mis_halt_req c=%0d: got %b want 0", c, IMemReq); end
            tick();
        end
`else
        IMemGnt = 1'b1;
        #1;
        n_cmp++; if (MisalignFault !== 1'b0) begin n_err++; $display("FAIL mis_fault: got %b want 0", MisalignFault); end
        n_cmp++; if (IMemReq !== 1'b1) begin n_err++; $display("FAIL mis_req: got %b want 1", IMemReq); end
        n_cmp++; if (IMemAddr !== 64'h200) begin n_err++; $display("FAIL mis_addr: got %h want 200", IMemAddr); end
        tick();
        IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'hC0DE_0001;
        tick();
        IMemRValid = 1'b0;
        #1;
        n_cmp++; if (InstPC !== 64'h200) begin n_err++; $display("FAIL mis_instpc: got %h want 200", InstPC); end
`endif
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        IMemGnt = 1'b1;
        tick();
        IMemGnt = 1'b0;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (IMemReq !== 1'b0) begin n_err++; $display("FAIL rmid_req: got %b want 0", IMemReq); end
        n_cmp++; if (IMemAddr !== 64'h0) begin n_err++; $display("FAIL rmid_addr: got %h want 0", IMemAddr); end
        tick();
        reset_n = 1'b1; IMemRValid = 1'b1; IMemRData = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (IMemReq !== 1'b1) begin n_err++; $display("FAIL rmid_restart_req: got %b want 1", IMemReq); end
        tick();
        IMemRValid = 1'b0;
        #1;
        n_cmp++; if (InstValid !== 1'b0) begin n_err++; $display("FAIL rmid_nopush: got %b want 0", InstValid); end
        n_cmp++; if (IMemAddr !== 64'h0) begin n_err++; $display("FAIL rmid_restart_addr: got %h want 0", IMemAddr); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_wait();
        test_branch_wrap();
        test_misalign();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage of the LEGv8 datapath. It holds the PC, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned instructions for decode. Decode receives `Inst25`, which feeds the sign-extension unit. The sign-extended, pre-shifted branch offset `SEUOut` comes back to this block and is added to the branch PC to redirect fetch.

## Interface
Parameters:
- `PC_RESET`, 64'h0: PC value loaded on reset.
- `IBUF_DEPTH`, 2: instruction buffer entries; power of two, ≥2.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `IMemReq`, out, 1: fetch request valid.
- `IMemAddr`, out, 64: fetch byte address (word aligned).
- `IMemGnt`, in, 1: memory accepts request this cycle.
- `IMemRValid`, in, 1: read data valid.
- `IMemRData`, in, 32: fetched instruction word.
- `BranchTaken`, in, 1: redirect fetch this cycle.
- `BranchPC`, in, 64: PC of the branch instruction.
- `SEUOut`, in, 64 signed: sign-extended, already-shifted byte offset.
- `InstValid`, out, 1: buffer head valid.
- `InstReady`, in, 1: decode consumes head.
- `Inst`, out, 32: head instruction.
- `InstPC`, out, 64: PC of head instruction.
- `Inst25`, out, 26: `Inst[25:0]` to the sign-extension unit.
- `MisalignFault`, out, 1: sticky misaligned-target flag (see Configuration).

## Operation
- FSM states:
  - FETCH: `IMemReq`=1 when `count+pending < IBUF_DEPTH`.
  - WAIT: one request outstanding.
  - DISCARD: outstanding response must be dropped after a redirect.
  - HALT: only with the trap macro.
- At most one outstanding request.
- FETCH → WAIT on `IMemReq & IMemGnt`; PC <= PC+4 (mod 2^64).
- WAIT → FETCH on `IMemRValid`; push {PC_of_request, `IMemRData`} into the buffer.
- Redirect (`BranchTaken`=1) has highest priority:
  - PC <= `BranchPC + SEUOut` (mod 2^64, two's complement).
  - Buffer flushed (count=0). A pop in the same cycle is ignored.
  - From WAIT without `IMemRValid`, go to DISCARD. Otherwise go to FETCH; a response in the same cycle is dropped.
  - A grant in the same cycle is cancelled: `IMemReq` is forced low during the `BranchTaken` cycle.
- DISCARD → FETCH on `IMemRValid`; the data is dropped, not pushed.
- Pop on `InstValid & InstReady`. Push and pop may occur in the same cycle.
- Buffer is a circular FIFO: rd/wr pointers wrap at `IBUF_DEPTH`.
  - Full: no request is issued, because `count+pending` is checked.
  - Empty: `InstValid`=0.
- `IMemRValid` in FETCH or HALT (no request pending) is ignored.

## Timing
- Reset values:
  - PC=`PC_RESET`, state=FETCH, count=0, pointers=0.
  - `IMemReq`=0 while `reset_n`=0; `IMemAddr`=`PC_RESET`.
  - `InstValid`=0, `Inst`=0, `InstPC`=0, `Inst25`=0, `MisalignFault`=0.
- Reset mid-operation:
  - All state clears immediately (asynchronous).
  - A response for a pre-reset request arriving after reset is ignored, because the state is FETCH.
- `IMemReq` and `IMemAddr` decode combinationally from registered state and PC (`BranchTaken` suppresses `IMemReq`).
- Latency: grant in cycle N, `IMemRValid` earliest N+1, `InstValid` in cycle N+2.
- Redirect: `BranchTaken` in cycle N gives `IMemAddr`=target in N+1, provided the state is not DISCARD.
- `Inst`, `InstPC` and `Inst25` come directly from the buffer head; they are zero when empty.
- Sustained throughput is 1 instruction per 2 cycles with single-cycle memory. This is acceptable.

## Configuration
- Macro: `IFU_MISALIGN_TRAP_EN`.
- Defined:
  - A redirect target with [1:0]≠0 sets `MisalignFault`=1 in the next cycle and enters HALT.
  - HALT: no requests; buffer flushed; exit only by reset.
- Undefined:
  - Target [1:0] is forced to 2'b00 and fetch continues.
  - `MisalignFault` is tied 0 and the HALT state is absent.

## Test plan
- Reset, then memory grants every request and returns data 1 cycle later → `IMemAddr` sequence 0,4,8,…; first `InstValid` in cycle 2 after reset release; `InstPC`=0.
- `InstReady`=0 with `IBUF_DEPTH`=2 → exactly 2 requests issued, then `IMemReq`=0; `InstReady`=1 resumes fetching one cycle later.
- `BranchTaken` with `BranchPC`=64'h100, `SEUOut`=-64'sd8, while in WAIT → next response dropped, buffer empty, next `IMemAddr`=64'hF8.
- `BranchPC`=64'hFFFF_FFFF_FFFF_FFFC, `SEUOut`=8 → target 64'h4 (wrap).
- `BranchTaken` with `SEUOut`=2 → with macro: `MisalignFault`=1 and no further `IMemReq`; without macro: target has low bits cleared, fetch continues.
- Assert `reset_n`=0 while in WAIT, release it, then pulse `IMemRValid` → no push; `InstValid` stays 0; fetch restarts at `PC_RESET`.
